// File: rtl/div_req_sched.sv
// -----------------------------------------------------------------------------
// div_req_sched
//
// Queues divide requests in a small FIFO and feeds them one at a time to an
// external fixed-latency shift-subtract divider, then presents each result
// with a valid/ready handshake. Only one divide is in flight at any time.
//
// Optional feature macro: DIV_DBZ_BYPASS_EN
//   When defined, a request with divisor 0 never reaches the divider. It goes
//   straight to DONE with quotient all ones, remainder 0 and out_dbz = 1.
//   When undefined, divisor 0 is issued like any other request and out_dbz
//   is tied low.
//
// Parameters:
//   WIDTH   - divisor width; dividend and quotient are 2*WIDTH bits
//   DEPTH   - request FIFO entries (power of two, >= 2)
//   LATENCY - cycles from the div_din_valid pulse to a stable divider result
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   in_valid / in_ready         - request handshake (in_ready = FIFO not full)
//   in_dividend, in_divisor     - request operands
//   div_dividend, div_divisor   - operands held for the divider
//   div_din_valid               - one-cycle divider start pulse
//   div_dout, div_remainder     - divider results
//   out_valid / out_ready       - result handshake
//   out_quotient, out_remainder - captured result (held while out_valid)
//   out_dbz                     - divide-by-zero flag
// -----------------------------------------------------------------------------
module div_req_sched #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 4 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_dividend,
    input  logic [WIDTH-1:0]     in_divisor,
    output logic [2*WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]     div_divisor,
    output logic                 div_din_valid,
    input  logic [2*WIDTH-1:0]   div_dout,
    input  logic [2*WIDTH-1:0]   div_remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_quotient,
    output logic [WIDTH-1:0]     out_remainder,
    output logic                 out_dbz
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Request FIFO storage and pointers
    logic [2*WIDTH-1:0] r_fifo_dvd [DEPTH];
    logic [WIDTH-1:0]   r_fifo_dvs [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    // Scheduler state and registered outputs
    state_t             r_state;
    logic [LW-1:0]      r_lat_cnt;
    logic [2*WIDTH-1:0] r_div_dividend;
    logic [WIDTH-1:0]   r_div_divisor;
    logic               r_din_valid;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_out_quotient;
    logic [WIDTH-1:0]   r_out_remainder;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_head_dvd;
    logic [WIDTH-1:0]   w_head_dvs;
    logic               w_rem_hi_unused;

    // The remainder can never exceed the divisor, so its upper half is unused.
    assign w_rem_hi_unused = ^div_remainder[2*WIDTH-1:WIDTH];

    assign w_full     = (r_count == CW'(DEPTH));
    assign in_ready   = !w_full;
    assign w_push     = in_valid && !w_full;
    // The head leaves the FIFO only when the scheduler is free to take it.
    assign w_pop      = (r_state == S_IDLE) && (r_count != {CW{1'b0}});
    assign w_head_dvd = r_fifo_dvd[r_rd_ptr];
    assign w_head_dvs = r_fifo_dvs[r_rd_ptr];

    // FIFO write, pointer wrap and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_dvd[i] <= {(2*WIDTH){1'b0}};
                r_fifo_dvs[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_fifo_dvd[r_wr_ptr] <= in_dividend;
                r_fifo_dvs[r_wr_ptr] <= in_divisor;
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef DIV_DBZ_BYPASS_EN
    logic r_out_dbz;
    assign out_dbz = r_out_dbz;
`else
    assign out_dbz = 1'b0;
`endif

    // Scheduler FSM: issue one divide, count out its latency, hold the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_lat_cnt       <= {LW{1'b0}};
            r_div_dividend  <= {(2*WIDTH){1'b0}};
            r_div_divisor   <= {WIDTH{1'b0}};
            r_din_valid     <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_quotient  <= {(2*WIDTH){1'b0}};
            r_out_remainder <= {WIDTH{1'b0}};
`ifdef DIV_DBZ_BYPASS_EN
            r_out_dbz       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_din_valid <= 1'b0;
                    if (w_pop) begin
                        // Operands stay in these registers until the capture.
                        r_div_dividend <= w_head_dvd;
                        r_div_divisor  <= w_head_dvs;
`ifdef DIV_DBZ_BYPASS_EN
                        if (w_head_dvs == {WIDTH{1'b0}}) begin
                            r_state         <= S_DONE;
                            r_out_valid     <= 1'b1;
                            r_out_quotient  <= {(2*WIDTH){1'b1}};
                            r_out_remainder <= {WIDTH{1'b0}};
                            r_out_dbz       <= 1'b1;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_din_valid <= 1'b1;
                        end
`else
                        r_state     <= S_ISSUE;
                        r_din_valid <= 1'b1;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // The start pulse was raised on entry; drop it after one cycle.
                    r_din_valid <= 1'b0;
                    r_lat_cnt   <= LW'(LATENCY - 1);
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_din_valid <= 1'b0;
                    if (r_lat_cnt == {LW{1'b0}}) begin
                        r_out_quotient  <= div_dout;
                        r_out_remainder <= div_remainder[WIDTH-1:0];
                        r_out_valid     <= 1'b1;
`ifdef DIV_DBZ_BYPASS_EN
                        r_out_dbz       <= 1'b0;
`endif
                        r_state         <= S_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LW'(1);
                    end
                end
                S_DONE: begin
                    r_din_valid <= 1'b0;
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_din_valid <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_lat_cnt   <= {LW{1'b0}};
                end
            endcase
        end
    end

    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;
    assign div_din_valid = r_din_valid;
    assign out_valid     = r_out_valid;
    assign out_quotient  = r_out_quotient;
    assign out_remainder = r_out_remainder;

endmodule

// File: tb/tb_div_req_sched.sv
module tb_div_req_sched;

    localparam int W   = 4;
    localparam int LAT = 16;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] in_dividend;
    logic [W-1:0]   in_divisor;
    logic [2*W-1:0] div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_din_valid;
    logic [2*W-1:0] div_dout;
    logic [2*W-1:0] div_remainder;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_quotient;
    logic [W-1:0]   out_remainder;
    logic           out_dbz;

    div_req_sched #(.WIDTH(W), .DEPTH(4), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_din_valid (div_din_valid),
        .div_dout      (div_dout),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dbz       (out_dbz)
    );

    typedef struct packed {
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dbz;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pulses  = 0;
    int   pulse_cyc = 0;
    int   accepted = 0;
    bit   t3_done  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider environment: result only becomes valid LAT cycles after the pulse.
    logic [2*W-1:0] m_a;
    logic [W-1:0]   m_b;
    logic [5:0]     m_cnt;
    logic           m_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 6'd0;
            m_a    <= 8'd0;
            m_b    <= 4'd0;
        end else if (div_din_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= 6'(LAT - 1);
            m_a    <= div_dividend;
            m_b    <= div_divisor;
        end else if (m_busy && m_cnt != 6'd0) begin
            m_cnt <= m_cnt - 6'd1;
        end
    end
    always_comb begin
        div_dout      = 8'hA5;
        div_remainder = 8'h5A;
        if (m_busy && m_cnt == 6'd0 && m_b != 4'd0) begin
            div_dout      = m_a / {4'd0, m_b};
            div_remainder = m_a % {4'd0, m_b};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every accepted result against the scoreboard head.
    logic           prev_valid = 1'b0;
    logic           prev_ready = 1'b0;
    logic [12:0]    prev_data  = 13'd0;
    always @(negedge clk) begin
        if (div_din_valid) begin
            pulses++;
            pulse_cyc = cyc;
        end
        if (rst_n && out_valid) begin
            if (!prev_valid) begin
                if (sb.size() == 0)
                    check("unexpected_result", 32'd1, 32'd0);
                else if (!sb[0].dbz)
                    check("result_latency", 32'(cyc - pulse_cyc), 32'd17);
            end
            if (prev_valid && !prev_ready)
                check("held_stable", {19'd0, out_quotient, out_remainder, out_dbz}, {19'd0, prev_data});
            if (out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", {24'd0, out_quotient}, {24'd0, e.q});
                check("remainder", {28'd0, out_remainder}, {28'd0, e.r});
                check("dbz", {31'd0, out_dbz}, {31'd0, e.dbz});
            end
        end
        prev_valid = rst_n && out_valid;
        prev_ready = out_ready;
        prev_data  = {out_quotient, out_remainder, out_dbz};
    end

    // Caller must be aligned #1 after a rising edge.
    task automatic push(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] q, input logic [3:0] r, input logic d);
        bit   ok;
        exp_t e;
        ok          = 1'b0;
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (ok) begin
            e.q = q; e.r = r; e.dbz = d;
            sb.push_back(e);
            accepted++;
        end else begin
            check("push_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 600; k++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        if (k == 600) check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int k;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = 8'd0;
        in_divisor  = 4'd0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_din_valid", {31'd0, div_din_valid}, 32'd0);
        check("rst_quotient", {24'd0, out_quotient}, 32'd0);
        check("rst_remainder", {28'd0, out_remainder}, 32'd0);
        check("rst_dbz", {31'd0, out_dbz}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single request, 200/7
        p0 = pulses;
        push(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        wait_drain();
        check("t1_pulses", 32'(pulses - p0), 32'd1);

        // Back-to-back requests, results in order
        p0 = pulses;
        push(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        push(8'd15, 4'd15, 8'd1, 4'd0, 1'b0);
        push(8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
        wait_drain();
        check("t2_pulses", 32'(pulses - p0), 32'd3);

        // Backpressure: 1 in flight + 4 queued, 6th stalls
        out_ready = 1'b0;
        accepted  = 0;
        t3_done   = 1'b0;
        fork
            begin
                push(8'd100, 4'd3, 8'd33, 4'd1, 1'b0);
                push(8'd99, 4'd10, 8'd9, 4'd9, 1'b0);
                push(8'd17, 4'd4, 8'd4, 4'd1, 1'b0);
                push(8'd250, 4'd15, 8'd16, 4'd10, 1'b0);
                push(8'd8, 4'd2, 8'd4, 4'd0, 1'b0);
                push(8'd77, 4'd7, 8'd11, 4'd0, 1'b0);
                t3_done = 1'b1;
            end
        join_none
        for (k = 0; k < 100 && !out_valid; k++) @(posedge clk);
        repeat (5) @(negedge clk);
        check("t3_accepted", 32'(accepted), 32'd5);
        check("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("t3_held_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (k = 0; k < 400 && !t3_done; k++) begin
            @(posedge clk);
            #1;
        end
        check("t3_sixth_accepted", 32'(accepted), 32'd6);
        wait_drain();

`ifdef DIV_DBZ_BYPASS_EN
        // Divide-by-zero bypass
        p0 = pulses;
        push(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1);
        @(negedge clk);
        check("byp_not_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("byp_valid_next", {31'd0, out_valid}, 32'd1);
        wait_drain();
        check("byp_no_pulse", 32'(pulses - p0), 32'd0);
`endif

        // Reset during WAIT with two requests queued
        push(8'd60, 4'd5, 8'd12, 4'd0, 1'b0);
        push(8'd61, 4'd5, 8'd12, 4'd1, 1'b0);
        push(8'd62, 4'd5, 8'd12, 4'd2, 1'b0);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_din_valid", {31'd0, div_din_valid}, 32'd0);
        check("mid_rst_quotient", {24'd0, out_quotient}, 32'd0);
        check("mid_rst_remainder", {28'd0, out_remainder}, 32'd0);
        check("mid_rst_dbz", {31'd0, out_dbz}, 32'd0);
        check("mid_rst_div_ops", {20'd0, div_dividend, div_divisor}, 32'd0);
        sb.delete();
        p0 = pulses;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_no_pulse", 32'(pulses - p0), 32'd0);
        check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
